seg_scan_capture: RTL and testbench



---
 rtl/seg_scan_capture.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Passive receiver for a multiplexed 8-digit seven-segment bus. It decodes
//   each scanned digit back to a hex code and assembles full frames. A frame
//   is published only after it has repeated MATCH_FRAMES times in a row.
//
//   Optional feature macro: SEG_SCAN_CAPTURE_DP_EN
//     When defined, seg_out[0] (the decimal point) is captured into dp and
//     takes part in the frame compare. When undefined, dp stays 0.
//
//   Ports
//     clk, rst     clock and synchronous active-high reset
//     seg_en[7:0]  digit strobes, active-low, one-hot-low selects a slot
//     seg_out[7:0] segments, active-low: bit7=a ... bit1=g, bit0=dp
//     digits[31:0] published codes, slot k at [4k+3:4k]
//     blank[7:0]   published blank flags
//     dp[7:0]      published decimal points
//     frame_valid  one-cycle pulse per published frame
//     changed      one-cycle pulse with frame_valid when the content changed
//     err          sticky flag for an unrecognised segment pattern
module seg_scan_capture #(
    parameter int unsigned SETTLE       = 4,
    parameter int unsigned MATCH_FRAMES = 2,
    parameter int unsigned TIMEOUT      = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_en,
    input  logic [7:0]  seg_out,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        changed,
    output logic        err
);
    localparam logic [7:0]  SETTLE_C  = SETTLE[7:0];
    localparam logic [3:0]  MATCH_C   = MATCH_FRAMES[3:0];
    localparam logic [23:0] TIMEOUT_C = TIMEOUT[23:0];

    // Returns {bad, blank, code} for an active-low a..g pattern.
    function automatic logic [5:0] decode(input logic [6:0] seg_n);
        logic [6:0] s;
        logic [5:0] r;
        s = ~seg_n;
        case (s)
            7'h7E: r = 6'h00;
            7'h30: r = 6'h01;
            7'h6D: r = 6'h02;
            7'h79: r = 6'h03;
            7'h33: r = 6'h04;
            7'h5B: r = 6'h05;
            7'h5F: r = 6'h06;
            7'h70: r = 6'h07;
            7'h7F: r = 6'h08;
            7'h7B: r = 6'h09;
            7'h77: r = 6'h0A;
            7'h1F: r = 6'h0B;
            7'h4E: r = 6'h0C;
            7'h3D: r = 6'h0D;
            7'h4F: r = 6'h0E;
            7'h47: r = 6'h0F;
            7'h00: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    logic [7:0]  en_q, en_prev_q, so_q;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  seen_q, seen_d;
    logic [23:0] to_q;
    logic [3:0]  match_q, match_d;
    logic [31:0] wcode_q, wcode_d;
    logic [7:0]  wblank_q, wblank_d, wdp_q, wdp_d;
    logic [31:0] prev_code_q, f_code;
    logic [7:0]  prev_blank_q, prev_dp_q, f_blank, f_dp;
    logic [31:0] digits_q;
    logic [7:0]  blank_q, dp_q;
    logic        fv_q, chg_q, err_q;

    logic [7:0]  inv;
    logic        idle, en_chg, smp, smp_dp, complete, publish, differs;
    logic [2:0]  slot;
    logic [5:0]  dec;

`ifdef SEG_SCAN_CAPTURE_DP_EN
    assign smp_dp = ~so_q[0];
`else
    logic unused_dp;
    assign unused_dp = so_q[0];
    assign smp_dp    = 1'b0;
`endif

    always_comb begin
        inv    = ~en_q;
        idle   = !$onehot(inv);
        slot   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (inv[k]) slot = 3'(k);
        end
        en_chg = (en_q != en_prev_q);

        // Dwell counter: restart on any strobe change, hold at SETTLE.
        if (idle)                    dwell_d = 8'd0;
        else if (en_chg)             dwell_d = 8'd1;
        else if (dwell_q < SETTLE_C) dwell_d = dwell_q + 8'd1;
        else                         dwell_d = dwell_q;

        // One sample per strobe value, on the cycle the dwell reaches SETTLE.
        smp = !idle && (dwell_d == SETTLE_C) && (en_chg || dwell_q != SETTLE_C);
        dec = decode(so_q[7:1]);

        wcode_d  = wcode_q;
        wblank_d = wblank_q;
        wdp_d    = wdp_q;
        seen_d   = seen_q;
        if (smp) begin
            wcode_d[{slot, 2'b00} +: 4] = dec[3:0];
            wblank_d[slot]              = dec[4];
            wdp_d[slot]                 = smp_dp;
            seen_d[slot]                = 1'b1;
        end

        complete = (seen_q == 8'hFF) || (seen_q != 8'h00 && to_q >= TIMEOUT_C);

        // Completed frame includes any same-cycle sample; unseen slots blank.
        f_code  = 32'h0;
        f_blank = 8'hFF;
        f_dp    = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (seen_d[k]) begin
                f_code[4*k +: 4] = wcode_d[4*k +: 4];
                f_blank[k]       = wblank_d[k];
                f_dp[k]          = wdp_d[k];
            end
        end

        if ({f_code, f_blank, f_dp} == {prev_code_q, prev_blank_q, prev_dp_q})
            match_d = (match_q == 4'd15) ? 4'd15 : match_q + 4'd1;
        else
            match_d = 4'd1;

        publish = complete && (match_d >= MATCH_C);
        differs = ({f_code, f_blank, f_dp} != {digits_q, blank_q, dp_q});
    end

    // Working buffer contents are qualified by seen_q and need no reset.
    always_ff @(posedge clk) begin
        wcode_q  <= wcode_d;
        wblank_q <= wblank_d;
        wdp_q    <= wdp_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= 8'hFF;
            en_prev_q    <= 8'hFF;
            so_q         <= 8'hFF;
            dwell_q      <= 8'd0;
            seen_q       <= 8'h00;
            to_q         <= 24'd0;
            match_q      <= 4'd0;
            prev_code_q  <= 32'h0;
            prev_blank_q <= 8'h00;
            prev_dp_q    <= 8'h00;
            digits_q     <= 32'h0;
            blank_q      <= 8'hFF;
            dp_q         <= 8'h00;
            fv_q         <= 1'b0;
            chg_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            en_q      <= seg_en;
            so_q      <= seg_out;
            en_prev_q <= en_q;
            dwell_q   <= dwell_d;
            fv_q      <= publish;
            chg_q     <= publish && differs;
            if (smp && dec[5]) err_q <= 1'b1;
            if (complete) begin
                seen_q       <= 8'h00;
                to_q         <= 24'd0;
                match_q      <= match_d;
                prev_code_q  <= f_code;
                prev_blank_q <= f_blank;
                prev_dp_q    <= f_dp;
                if (publish) begin
                    digits_q <= f_code;
                    blank_q  <= f_blank;
                    dp_q     <= f_dp;
                end
            end else begin
                seen_q <= seen_d;
                // Timeout counter only runs while a frame is open.
                to_q   <= (seen_q != 8'h00) ? to_q + 24'd1 : 24'd0;
            end
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign dp          = dp_q;
    assign frame_valid = fv_q;
    assign changed     = chg_q;
    assign err         = err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        changed;
    logic        err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int chg_cnt = 0;
    int fv_base;
    int chg_base;

    seg_scan_capture #(.SETTLE(4), .MATCH_FRAMES(2), .TIMEOUT(200)) dut (
        .clk(clk), .rst(rst), .seg_en(seg_en), .seg_out(seg_out),
        .digits(digits), .blank(blank), .dp(dp),
        .frame_valid(frame_valid), .changed(changed), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (changed === 1'b1) chg_cnt++;
    end

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h7E; 4'h1: g = 7'h30; 4'h2: g = 7'h6D; 4'h3: g = 7'h79;
            4'h4: g = 7'h33; 4'h5: g = 7'h5B; 4'h6: g = 7'h5F; 4'h7: g = 7'h70;
            4'h8: g = 7'h7F; 4'h9: g = 7'h7B; 4'hA: g = 7'h77; 4'hB: g = 7'h1F;
            4'hC: g = 7'h4E; 4'hD: g = 7'h3D; 4'hE: g = 7'h4F; default: g = 7'h47;
        endcase
        return {~g, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int slot, input logic [7:0] pat, input int len);
        logic [7:0] e;
        e = 8'h01 << slot;
        seg_en  = ~e;
        seg_out = pat;
        repeat (len) @(negedge clk);
    endtask

    task automatic idle(input int n);
        seg_en  = 8'hFF;
        seg_out = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] codes, input logic [7:0] mask,
                         input int short_slot, input int short_len);
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) strobe(k, seg7(codes[4*k +: 4]), (k == short_slot) ? short_len : 10);
        end
    endtask

    initial begin
        rst = 1'b1;
        seg_en = 8'hFF;
        seg_out = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 32'h0);
        chk("rst_blank", {24'h0, blank}, 32'hFF);
        chk("rst_dp", {24'h0, dp}, 32'h0);
        chk("rst_fv", {31'h0, frame_valid}, 32'h0);
        chk("rst_changed", {31'h0, changed}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Two identical frames publish once, with changed.
        frame(32'h0012_3456, 8'hFF, -1, 0);
        frame(32'h0012_3456, 8'hFF, -1, 0);
        idle(10);
        chk("basic_fv_cnt", fv_cnt, 1);
        chk("basic_chg_cnt", chg_cnt, 1);
        chk("basic_digits", digits, 32'h0012_3456);
        chk("basic_blank", {24'h0, blank}, 32'h0);
        chk("basic_dp", {24'h0, dp}, 32'h0);
        // A third identical frame republishes without changed.
        frame(32'h0012_3456, 8'hFF, -1, 0);
        idle(10);
        chk("repeat_fv_cnt", fv_cnt, 2);
        chk("repeat_chg_cnt", chg_cnt, 1);

        // Alternating frames never reach the match threshold.
        for (int i = 0; i < 3; i++) begin
            frame(32'h1234_5678, 8'hFF, -1, 0);
            frame(32'h1234_5679, 8'hFF, -1, 0);
        end
        idle(10);
        chk("alt_fv_cnt", fv_cnt, 2);
        chk("alt_digits", digits, 32'h0012_3456);

        // Slot 6 never strobed: frames close on timeout, slot 6 blank.
        fv_base = fv_cnt;
        chg_base = chg_cnt;
        frame(32'h1234_5678, 8'hBF, -1, 0);
        idle(160);
        frame(32'h1234_5678, 8'hBF, -1, 0);
        idle(160);
        chk("to6_fv", fv_cnt - fv_base, 1);
        chk("to6_chg", chg_cnt - chg_base, 1);
        chk("to6_digits", digits, 32'h1034_5678);
        chk("to6_blank", {24'h0, blank}, 32'h40);

        // Slot 3 held too briefly: never sampled, blank after timeout.
        fv_base = fv_cnt;
        frame(32'h9876_5432, 8'hFF, 3, 3);
        idle(160);
        frame(32'h9876_5432, 8'hFF, 3, 3);
        idle(160);
        chk("short3_fv", fv_cnt - fv_base, 1);
        chk("short3_digits", digits, 32'h9876_0432);
        chk("short3_blank", {24'h0, blank}, 32'h08);

        // Unrecognised pattern on slot 0 sets sticky err.
        frame(32'h0012_3456, 8'hFE, -1, 0);
        strobe(0, 8'b1001_0011, 10);
        idle(5);
        chk("err_set", {31'h0, err}, 32'h1);
        fv_base = fv_cnt;
        frame(32'h0012_3456, 8'hFF, -1, 0);
        frame(32'h0012_3456, 8'hFF, -1, 0);
        idle(10);
        chk("err_sticky", {31'h0, err}, 32'h1);
        chk("err_good_fv", fv_cnt - fv_base, 1);
        chk("err_good_digits", digits, 32'h0012_3456);

        // Reset mid-frame with slots 3..0 seen.
        frame(32'h0012_3456, 8'h0F, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_digits", digits, 32'h0);
        chk("mid_rst_blank", {24'h0, blank}, 32'hFF);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        chk("mid_rst_fv", {31'h0, frame_valid}, 32'h0);
        rst = 1'b0;
        idle(2);
        fv_base = fv_cnt;
        chg_base = chg_cnt;
        frame(32'h0012_3456, 8'hFF, -1, 0);
        frame(32'h0012_3456, 8'hFF, -1, 0);
        idle(10);
        chk("post_rst_fv", fv_cnt - fv_base, 1);
        chk("post_rst_chg", chg_cnt - chg_base, 1);
        chk("post_rst_digits", digits, 32'h0012_3456);
        chk("post_rst_blank", {24'h0, blank}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
